// File: rtl/jpeg_sof_ctrl.sv
// SOF0 baseline frame header sequencer: walks length, resolution and three component records.
// Define JPEG_SOF_CHECK_EN to enable header validation and the ERR state.
`ifndef STATE_RST
`define STATE_RST 4'd1
`endif
`ifndef STATE_SOF
`define STATE_SOF 4'd2
`endif

module jpeg_sof_ctrl #(
    parameter int SIZE_BITS = 16,
    parameter int RESO_BITS = 48,
    parameter int COMP_BITS = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  state,
    input  logic        bit_avali,
    input  logic [63:0] bit_out,
    output logic [2:0]  sof_state,
    output logic        bit_shift,
    output logic [6:0]  bit_len,
    output logic        sof_busy,
    output logic        sof_done,
    output logic        sof_err
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SIZE = 3'd1,
        S_RESO = 3'd2,
        S_Y    = 3'd3,
        S_CR   = 3'd4,
        S_CB   = 3'd5,
        S_DONE = 3'd6,
        S_ERR  = 3'd7
    } sof_st_t;

    sof_st_t state_r;
    sof_st_t next_s;
    logic    in_sof_s;
    logic    soft_clr_s;
    logic    consuming_s;
    logic    consume_s;
    logic    check_fail_s;
    logic    done_r;
    logic    busy_r;

    // Successor of each consuming phase in the normal header order.
    function automatic sof_st_t next_field(input sof_st_t cur);
        case (cur)
            S_SIZE:  next_field = S_RESO;
            S_RESO:  next_field = S_Y;
            S_Y:     next_field = S_CR;
            S_CR:    next_field = S_CB;
            S_CB:    next_field = S_DONE;
            default: next_field = S_IDLE;
        endcase
    endfunction

    assign in_sof_s    = (state == `STATE_SOF);
    assign soft_clr_s  = (state == `STATE_RST);
    assign consuming_s = (state_r == S_SIZE) || (state_r == S_RESO) || (state_r == S_Y) ||
                         (state_r == S_CR) || (state_r == S_CB);
    // Reset, soft clear and abort all suppress the consume in the same cycle.
    assign consume_s   = consuming_s && bit_avali && in_sof_s && !rst;

`ifdef JPEG_SOF_CHECK_EN
    logic [15:0] len_q;
    logic        err_r;
    logic        unused_s;

    function automatic logic reso_ok(input logic [47:0] reso, input logic [15:0] len);
        reso_ok = (reso[47:40] == 8'd8) && (reso[7:0] == 8'd3) && (len == 16'd17) &&
                  (reso[39:24] != 16'd0) && (reso[23:8] != 16'd0);
    endfunction

    function automatic logic y_factor_ok(input logic [7:0] factor);
        y_factor_ok = (factor == 8'h11) || (factor == 8'h22);
    endfunction

    assign unused_s = ^bit_out[15:0];

    // Length field capture, cleared by either reset source.
    always_ff @(posedge clk) begin
        if (rst || soft_clr_s) begin
            len_q <= 16'd0;
        end else if (consume_s && (state_r == S_SIZE)) begin
            len_q <= bit_out[63:48];
        end else begin
            len_q <= len_q;
        end
    end

    // Field validation on the window being consumed this cycle.
    always_comb begin
        check_fail_s = 1'b0;
        case (state_r)
            S_RESO:     check_fail_s = !reso_ok(bit_out[63:16], len_q);
            S_Y:        check_fail_s = !y_factor_ok(bit_out[55:48]);
            S_CR, S_CB: check_fail_s = (bit_out[55:48] != 8'h11);
            default:    check_fail_s = 1'b0;
        endcase
    end

    // Error level register.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= 1'b0;
        end else begin
            err_r <= (next_s == S_ERR);
        end
    end

    assign sof_err = err_r;
`else
    logic unused_s;

    assign unused_s     = ^bit_out;
    assign check_fail_s = 1'b0;
    assign sof_err      = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state logic; the soft clear outranks every other transition.
    always_comb begin
        next_s = state_r;
        if (soft_clr_s) begin
            next_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (in_sof_s) next_s = S_SIZE;
                    else          next_s = S_IDLE;
                end
                S_SIZE, S_RESO, S_Y, S_CR, S_CB: begin
                    if (!in_sof_s)         next_s = S_IDLE;
                    else if (!bit_avali)   next_s = state_r;
                    else if (check_fail_s) next_s = S_ERR;
                    else                   next_s = next_field(state_r);
                end
                S_DONE: begin
                    if (in_sof_s) next_s = S_DONE;
                    else          next_s = S_IDLE;
                end
                S_ERR:   next_s = S_ERR;
                default: next_s = S_IDLE;
            endcase
        end
    end

    // Consume request and length toward the bit buffer.
    always_comb begin
        bit_len = 7'd0;
        if (consume_s) begin
            case (state_r)
                S_SIZE:           bit_len = 7'(SIZE_BITS);
                S_RESO:           bit_len = 7'(RESO_BITS);
                S_Y, S_CR, S_CB:  bit_len = 7'(COMP_BITS);
                default:          bit_len = 7'd0;
            endcase
        end else begin
            bit_len = 7'd0;
        end
    end

    assign bit_shift = consume_s;

    // Registered status flags derived from the upcoming state.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_r <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            done_r <= (next_s == S_DONE) && (state_r != S_DONE);
            busy_r <= (next_s == S_SIZE) || (next_s == S_RESO) || (next_s == S_Y) ||
                      (next_s == S_CR) || (next_s == S_CB);
        end
    end

    assign sof_state = state_r;
    assign sof_busy  = busy_r;
    assign sof_done  = done_r;

endmodule

// File: tb/tb_jpeg_sof_ctrl.sv
// Self-checking bench for jpeg_sof_ctrl: per-cycle stimulus and expectations queued, then replayed.
`ifndef STATE_RST
`define STATE_RST 4'd1
`endif
`ifndef STATE_SOF
`define STATE_SOF 4'd2
`endif

module tb_jpeg_sof_ctrl;

    localparam logic [3:0] SOF = `STATE_SOF;
    localparam logic [3:0] RST = `STATE_RST;
    localparam logic [3:0] OTH = 4'd0;

    logic        clk;
    logic        rst;
    logic [3:0]  state;
    logic        bit_avali;
    logic [63:0] bit_out;
    logic [2:0]  sof_state;
    logic        bit_shift;
    logic [6:0]  bit_len;
    logic        sof_busy;
    logic        sof_done;
    logic        sof_err;

    logic [255:0] stream;
    int           ptr;
    logic         tb_load;

    typedef struct {
        logic [3:0] st;
        logic       av;
        logic       ld;
        logic [2:0] ss;
        logic [6:0] len;
        logic       done;
        logic       err;
    } item_t;

    item_t q[$];
    int    n_checks;
    int    n_errors;
    string cur_case;

    jpeg_sof_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .state     (state),
        .bit_avali (bit_avali),
        .bit_out   (bit_out),
        .sof_state (sof_state),
        .bit_shift (bit_shift),
        .bit_len   (bit_len),
        .sof_busy  (sof_busy),
        .sof_done  (sof_done),
        .sof_err   (sof_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit buffer model: MSB-aligned window, advanced by each accepted consume.
    assign bit_out = stream[255 - ptr -: 64];
    always @(posedge clk) begin
        if (tb_load) ptr <= 0;
        else if (bit_shift) ptr <= ptr + int'(bit_len);
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] st, input logic av, input logic ld, input logic [2:0] ss,
                        input logic [6:0] len, input logic done, input logic err);
        item_t it;
        it.st = st; it.av = av; it.ld = ld; it.ss = ss; it.len = len; it.done = done; it.err = err;
        q.push_back(it);
    endtask

    task automatic run_queue();
        int cyc = 0;
        while (q.size() > 0) begin
            item_t it = q.pop_front();
            @(negedge clk);
            state = it.st; bit_avali = it.av; tb_load = it.ld;
            #1;
            check_val($sformatf("%s c%0d sof_state", cur_case, cyc), 32'(sof_state), 32'(it.ss));
            check_val($sformatf("%s c%0d bit_len", cur_case, cyc), 32'(bit_len), 32'(it.len));
            check_val($sformatf("%s c%0d bit_shift", cur_case, cyc), 32'(bit_shift), 32'(it.len != 7'd0));
            check_val($sformatf("%s c%0d sof_done", cur_case, cyc), 32'(sof_done), 32'(it.done));
            check_val($sformatf("%s c%0d sof_err", cur_case, cyc), 32'(sof_err), 32'(it.err));
            check_val($sformatf("%s c%0d sof_busy", cur_case, cyc), 32'(sof_busy),
                      32'((it.ss >= 3'd1) && (it.ss <= 3'd5)));
            cyc++;
        end
        @(negedge clk);
        tb_load = 1'b0;
    endtask

    task automatic do_reset(input logic [255:0] s);
        @(negedge clk);
        rst = 1'b1; state = SOF; bit_avali = 1'b1; tb_load = 1'b1; stream = s;
        @(negedge clk);
        @(negedge clk);
        check_val({cur_case, " reset sof_state"}, 32'(sof_state), 32'd0);
        check_val({cur_case, " reset bit_shift"}, 32'(bit_shift), 32'd0);
        check_val({cur_case, " reset bit_len"}, 32'(bit_len), 32'd0);
        check_val({cur_case, " reset flags"}, {29'd0, sof_busy, sof_done, sof_err}, 32'd0);
        rst = 1'b0; state = OTH; tb_load = 1'b0;
    endtask

    // Cycles 0..5 of a header with data always available.
    task automatic push_head(input int upto);
        logic [6:0] lens [6] = '{7'd0, 7'd16, 7'd48, 7'd24, 7'd24, 7'd24};
        for (int i = 0; i <= upto; i++) push(SOF, 1'b1, 1'b0, 3'(i), lens[i], 1'b0, 1'b0);
    endtask

    task automatic push_done_tail(input int extra_hold);
        push(SOF, 1'b1, 1'b0, 3'd6, 7'd0, 1'b1, 1'b0);
        for (int i = 0; i < extra_hold; i++) push(SOF, 1'b1, 1'b0, 3'd6, 7'd0, 1'b0, 1'b0);
        push(OTH, 1'b1, 1'b0, 3'd6, 7'd0, 1'b0, 1'b0);
        push(OTH, 1'b1, 1'b0, 3'd0, 7'd0, 1'b0, 1'b0);
    endtask

    logic [255:0] good_s, bad_prec_s, bad_y_s;

    initial begin
        n_checks = 0; n_errors = 0;
        rst = 1'b1; state = OTH; bit_avali = 1'b0; tb_load = 1'b1; ptr = 0;
        good_s     = {16'h0011, 8'h08, 16'h00F0, 16'h0140, 8'h03, 24'h012200, 24'h021101, 24'h031101, 120'd0};
        bad_prec_s = {16'h0011, 8'h0C, 16'h00F0, 16'h0140, 8'h03, 24'h012200, 24'h021101, 24'h031101, 120'd0};
        bad_y_s    = {16'h0011, 8'h08, 16'h00F0, 16'h0140, 8'h03, 24'h012100, 24'h021101, 24'h031101, 120'd0};
        stream = good_s;

        cur_case = "nominal";
        do_reset(good_s);
        push_head(5);
        push_done_tail(2);
        run_queue();
        check_val("nominal consumed bits", 32'(ptr), 32'd136);

        cur_case = "stall";
        do_reset(good_s);
        push_head(2);
        for (int i = 0; i < 3; i++) push(SOF, 1'b0, 1'b0, 3'd3, 7'd0, 1'b0, 1'b0);
        push(SOF, 1'b1, 1'b0, 3'd3, 7'd24, 1'b0, 1'b0);
        push(SOF, 1'b1, 1'b0, 3'd4, 7'd24, 1'b0, 1'b0);
        push(SOF, 1'b1, 1'b0, 3'd5, 7'd24, 1'b0, 1'b0);
        push_done_tail(0);
        run_queue();

        cur_case = "bad_prec";
        do_reset(bad_prec_s);
        push_head(2);
`ifdef JPEG_SOF_CHECK_EN
        push(SOF, 1'b1, 1'b0, 3'd7, 7'd0, 1'b0, 1'b1);
        push(OTH, 1'b1, 1'b0, 3'd7, 7'd0, 1'b0, 1'b1);
        push(RST, 1'b1, 1'b0, 3'd7, 7'd0, 1'b0, 1'b1);
        push(OTH, 1'b1, 1'b0, 3'd0, 7'd0, 1'b0, 1'b0);
        run_queue();
        check_val("bad_prec consumed bits", 32'(ptr), 32'd64);
`else
        push(SOF, 1'b1, 1'b0, 3'd3, 7'd24, 1'b0, 1'b0);
        push(SOF, 1'b1, 1'b0, 3'd4, 7'd24, 1'b0, 1'b0);
        push(SOF, 1'b1, 1'b0, 3'd5, 7'd24, 1'b0, 1'b0);
        push_done_tail(0);
        run_queue();
`endif

        cur_case = "bad_y";
        do_reset(bad_y_s);
        push_head(3);
`ifdef JPEG_SOF_CHECK_EN
        push(SOF, 1'b1, 1'b0, 3'd7, 7'd0, 1'b0, 1'b1);
        push(RST, 1'b1, 1'b0, 3'd7, 7'd0, 1'b0, 1'b1);
        push(SOF, 1'b1, 1'b0, 3'd0, 7'd0, 1'b0, 1'b0);
        push(OTH, 1'b1, 1'b0, 3'd1, 7'd0, 1'b0, 1'b0);
        push(OTH, 1'b1, 1'b0, 3'd0, 7'd0, 1'b0, 1'b0);
        run_queue();
`else
        push(SOF, 1'b1, 1'b0, 3'd4, 7'd24, 1'b0, 1'b0);
        push(SOF, 1'b1, 1'b0, 3'd5, 7'd24, 1'b0, 1'b0);
        push_done_tail(0);
        run_queue();
`endif

        cur_case = "rst_in_cr";
        do_reset(good_s);
        push_head(3);
        push(RST, 1'b1, 1'b0, 3'd4, 7'd0, 1'b0, 1'b0);
        push(OTH, 1'b1, 1'b1, 3'd0, 7'd0, 1'b0, 1'b0);
        push_head(5);
        push_done_tail(0);
        run_queue();
        check_val("rst_in_cr consumed bits", 32'(ptr), 32'd136);

        cur_case = "abort_reso";
        do_reset(good_s);
        push_head(1);
        push(OTH, 1'b1, 1'b0, 3'd2, 7'd0, 1'b0, 1'b0);
        push(OTH, 1'b1, 1'b0, 3'd0, 7'd0, 1'b0, 1'b0);
        run_queue();
        check_val("abort_reso consumed bits", 32'(ptr), 32'd16);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
